// File: rtl/pong_pkg.sv
// Shared types and default timing for the pong paddle input path.
// Default cycle counts assume a 25 MHz pixel clock.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } step_state_t;

  localparam int CLK_HZ                  = 25_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250_000;    // 10 ms
  localparam int DEFAULT_REPEAT_DELAY    = 6_250_000;  // 250 ms
  localparam int DEFAULT_REPEAT_PERIOD   = 312_500;    // 12.5 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter.
// stable is the debounced level; level is its registered copy, one cycle later.
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          level_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      level_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      level_reg <= stable_reg;
      // Any cycle where the synchronised value agrees restarts the count.
      if (sync2_reg == stable_reg) begin
        count_reg <= '0;
      end else if (count_reg == COUNT_LAST) begin
        stable_reg <= sync2_reg;
        count_reg  <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign level  = level_reg;

endmodule

// File: rtl/paddle_btn_conditioner.sv
// Debounces the two paddle buttons and turns each into a first step plus a
// typematic repeat stream of single-cycle strobes.
module paddle_btn_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up_level,
  output logic down_level,
  output logic step_up,
  output logic step_down
);

  localparam int TMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  logic [1:0] btn_raw;
  logic [1:0] lvl_stable;
  logic [1:0] lvl_out;
  logic [1:0] dir_active;
  logic [1:0] step_out;

  assign btn_raw = {btn_down, btn_up};

  // A direction counts as active only when its level is high both now and in
  // the coming cycle, so no strobe ever lands in the cycle a level falls.
  assign dir_active[0] = lvl_out[0] & lvl_stable[0] & ~lvl_out[1] & ~lvl_stable[1];
  assign dir_active[1] = lvl_out[1] & lvl_stable[1] & ~lvl_out[0] & ~lvl_stable[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      step_state_t   state_reg, state_next;
      logic [TW-1:0] timer_reg, timer_next;
      logic          step_reg,  step_next;

      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_raw[gi]),
        .stable (lvl_stable[gi]),
        .level  (lvl_out[gi])
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
          timer_reg <= '0;
          step_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          timer_reg <= timer_next;
          step_reg  <= step_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        step_next  = 1'b0;
        if (!dir_active[gi]) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              state_next = DELAY;
              timer_next = DELAY_LOAD;
              step_next  = 1'b1;
            end
            DELAY, REPEAT: begin
              if (timer_reg == '0) begin
                state_next = REPEAT;
                timer_next = PERIOD_LOAD;
                step_next  = 1'b1;
              end else begin
                timer_next = timer_reg - 1'b1;
              end
            end
            default: begin
              state_next = IDLE;
              timer_next = '0;
            end
          endcase
        end
      end

      assign step_out[gi] = step_reg;
    end
  endgenerate

  assign up_level   = lvl_out[0];
  assign down_level = lvl_out[1];
  assign step_up    = step_out[0];
  assign step_down  = step_out[1];

endmodule

// File: tb/tb_paddle_btn_conditioner.sv
// Randomised and directed stimulus compared every cycle against a window-based
// reference model of debounced levels and the press/repeat strobe schedule.
module tb_paddle_btn_conditioner;

  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int NMAX = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic up_level, down_level, step_up, step_down;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit rst_h [NMAX];
  bit raw_u [NMAX];
  bit raw_d [NMAX];
  bit lvl_u [NMAX];
  bit lvl_d [NMAX];
  bit act_prev [2];
  int t0 [2];

  paddle_btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .up_level   (up_level),
    .down_level (down_level),
    .step_up    (step_up),
    .step_down  (step_down)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Level after edge n flips when the last D samples that reached the
  // debouncer all disagree with it and no reset interrupted that window.
  function automatic bit model_level(input int which, input int n);
    bit prev, cand, ok, r, eff;
    prev = 1'b0;
    if (n > 0) prev = which ? lvl_d[n-1] : lvl_u[n-1];
    if (rst_h[n]) return 1'b0;
    if (n < D + 3) return prev;
    cand = ~prev;
    ok = 1'b1;
    for (int k = n - D - 2; k <= n - 3; k++) begin
      r = which ? raw_d[k] : raw_u[k];
      eff = r & ~rst_h[k] & ~rst_h[k+1];
      if (eff != cand) ok = 1'b0;
    end
    for (int j = n - D; j <= n - 1; j++)
      if (rst_h[j]) ok = 1'b0;
    return ok ? cand : prev;
  endfunction

  function automatic bit model_step(input int which, input bit a, input int n);
    bit s;
    int d;
    s = 1'b0;
    if (a) begin
      if (!act_prev[which]) begin
        t0[which] = n;
        s = 1'b1;
      end else begin
        d = n - t0[which];
        s = (d >= RD) && (((d - RD) % RP) == 0);
      end
    end
    act_prev[which] = a;
    return s;
  endfunction

  task automatic tick(input bit r, input bit u, input bit d);
    bit a_u, a_d, e_su, e_sd, pu, pd;
    reset = r;
    btn_up = u;
    btn_down = d;
    @(posedge clk);
    if (cyc >= NMAX) begin
      $display("FAIL overrun cyc=%0d got=%0d exp=%0d", cyc, cyc, NMAX - 1);
      $fatal(1);
    end
    rst_h[cyc] = r;
    raw_u[cyc] = u;
    raw_d[cyc] = d;
    lvl_u[cyc] = model_level(0, cyc);
    lvl_d[cyc] = model_level(1, cyc);
    pu = (cyc > 0) ? lvl_u[cyc-1] : 1'b0;
    pd = (cyc > 0) ? lvl_d[cyc-1] : 1'b0;
    a_u = ~r & pu & lvl_u[cyc] & ~pd & ~lvl_d[cyc];
    a_d = ~r & pd & lvl_d[cyc] & ~pu & ~lvl_u[cyc];
    e_su = model_step(0, a_u, cyc);
    e_sd = model_step(1, a_d, cyc);
    @(negedge clk);
    check("up_level", int'(up_level), int'(lvl_u[cyc]));
    check("down_level", int'(down_level), int'(lvl_d[cyc]));
    check("step_up", int'(step_up), int'(e_su));
    check("step_down", int'(step_down), int'(e_sd));
    check("excl", int'(step_up & step_down), 0);
    $display("cyc=%0d rst=%0d up=%0d dn=%0d | lu=%0d ld=%0d su=%0d sd=%0d",
             cyc, r, u, d, up_level, down_level, step_up, step_down);
    cyc++;
  endtask

  task automatic run(input int n, input bit r, input bit u, input bit d);
    for (int i = 0; i < n; i++) tick(r, u, d);
  endtask

  initial begin
    int press_cyc, lvl_lat, step_lat, len;
    bit ru, rd, rr, lvl_seen;

    run(3, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0);

    // Clean press held 40 cycles, with explicit latency measurement.
    press_cyc = cyc;
    lvl_lat = -1;
    step_lat = -1;
    lvl_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (up_level && !lvl_seen) begin
        lvl_seen = 1'b1;
        lvl_lat = cyc - 1 - press_cyc;
      end
      if (step_up && step_lat < 0) step_lat = cyc - 1 - press_cyc;
    end
    check("press_level_lat", lvl_lat, D + 2);
    check("press_step_lat", step_lat, D + 3);
    run(15, 1'b0, 1'b0, 1'b0);

    // Bounce on down with pulses shorter than the debounce window.
    len = 0;
    rd = 1'b1;
    while (len < 30) begin
      int w;
      w = int'($urandom_range(1, 3));
      run(w, 1'b0, 1'b0, rd);
      rd = ~rd;
      len += w;
    end
    run(15, 1'b0, 1'b0, 1'b0);

    // Both held, then release up so down takes over.
    run(25, 1'b0, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1, 1'b1);
    run(30, 1'b0, 1'b0, 1'b1);
    run(15, 1'b0, 1'b0, 1'b0);

    // Reset mid-repeat with the button still held.
    run(25, 1'b0, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1, 1'b0);
    run(12, 1'b0, 1'b0, 1'b0);

    // Release timed so the level falls on a repeat-due cycle.
    run(14, 1'b0, 1'b1, 1'b0);
    run(12, 1'b0, 1'b0, 1'b0);

    // Random segments.
    for (int s = 0; s < 50; s++) begin
      rr = ($urandom_range(0, 14) == 0);
      ru = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      for (int i = 0; i < len; i++) begin
        bit nu;
        nu = ru;
        if ($urandom_range(0, 11) == 0) nu = ~ru;
        tick(rr && (i < 2), nu, rd);
      end
    end
    run(12, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
